// File: rtl/b_muldiv_unit_if.sv
// Issue/result bundle between the control unit and the HI/LO multiply/divide unit.
// The control unit drives the master side; the unit implements the slave side.
interface b_muldiv_unit_if #(
    parameter int width = 32
);
    logic             start;
    logic [1:0]       op;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic             busy;
    logic             done;
    logic [width-1:0] hi;
    logic [width-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/b_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit.
// Uses shift-add multiply and restoring divide, one bit per cycle, on operand magnitudes with a final sign fix.
module b_muldiv_unit #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    b_muldiv_unit_if.slave   bus
);
    localparam int CW = $clog2(width);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         op_q;
    logic [width-1:0]   a_raw_q;
    logic [width-1:0]   a_mag_q;
    logic [width-1:0]   b_mag_q;
    logic               b_zero_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [2*width-1:0] p_q, p_d;
    logic               busy_q, done_q, div_zero_q;
    logic [width-1:0]   hi_q, lo_q;

    // Issue-time operand conditioning: op[0]=1 selects the unsigned variants.
    logic             is_signed;
    logic             a_neg, b_neg;
    logic [width-1:0] a_mag, b_mag;

    assign is_signed = ~bus.op[0];
    assign a_neg     = is_signed & bus.a[width-1];
    assign b_neg     = is_signed & bus.b[width-1];
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;

    logic [width:0]     mul_sum;
    logic [width:0]     div_sh;
    logic [width:0]     div_rem;
    logic               div_geq;
    logic [2*width-1:0] prod_fix;
    logic [width-1:0]   quot_fix, rem_fix;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        p_d     = p_q;
        mul_sum = {1'b0, p_q[2*width-1:width]} + (p_q[0] ? {1'b0, a_mag_q} : '0);
        div_sh  = {p_q[2*width-1:width], p_q[width-1]};
        div_geq = div_sh >= {1'b0, b_mag_q};
        div_rem = div_geq ? div_sh - {1'b0, b_mag_q} : div_sh;
        if (op_q[1]) begin
            p_d = {div_rem[width-1:0], p_q[width-2:0], div_geq};
        end else begin
            p_d = {mul_sum, p_q[width-1:1]};
        end
        prod_fix = neg_res_q ? -p_q : p_q;
        quot_fix = neg_res_q ? -p_q[width-1:0] : p_q[width-1:0];
        rem_fix  = neg_rem_q ? -p_q[2*width-1:width] : p_q[2*width-1:width];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_raw_q    <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            b_zero_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            p_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        op_q      <= bus.op;
                        a_raw_q   <= bus.a;
                        a_mag_q   <= a_mag;
                        b_mag_q   <= b_mag;
                        b_zero_q  <= (bus.b == '0);
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        // Multiply walks the multiplier in the low half; divide shifts the dividend out of it.
                        p_q       <= {{width{1'b0}}, bus.op[1] ? a_mag : b_mag};
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(width - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (!op_q[1]) begin
                        hi_q       <= prod_fix[2*width-1:width];
                        lo_q       <= prod_fix[width-1:0];
                        div_zero_q <= 1'b0;
                    end else if (b_zero_q) begin
                        hi_q       <= a_raw_q;
                        lo_q       <= '1;
                        div_zero_q <= 1'b1;
                    end else begin
                        hi_q       <= rem_fix;
                        lo_q       <= quot_fix;
                        div_zero_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_b_muldiv_unit.sv
// Directed bench for b_muldiv_unit: hand-computed products, quotients, corner cases,
// handshake timing, ignored restarts and asynchronous abort.
module tb_b_muldiv_unit;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    b_muldiv_unit_if #(.width(32)) bus ();

    b_muldiv_unit #(.width(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and waits (bounded) for done; returns edges after E0 and busy cycles seen.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                                input logic dz);
        check({tag, " hi"}, 64'(bus.hi), 64'(hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(lo));
        check({tag, " div_zero"}, 64'(bus.div_zero), 64'(dz));
    endtask

    initial begin
        int lat, bcnt, dones, first_done;
        logic [31:0] hi_at_done, lo_at_done;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check_result("reset", 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: unsigned max product, full handshake timing
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        check("t1 latency", 64'(lat), 64'd33);
        check("t1 busy cycles", 64'(bcnt), 64'd33);
        check("t1 busy in DONE", 64'(bus.busy), 64'd0);
        check_result("t1", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        tick();
        check("t1 done pulse width", 64'(bus.done), 64'd0);

        // 2: signed multiply with mixed signs
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
        check("t2 latency", 64'(lat), 64'd33);
        check_result("t2", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

        // 3: DIVU then back-to-back signed DIV issued during DONE
        tick();
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
        check_result("t3a", 32'd2, 32'd14, 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("t3b latency", 64'(lat), 64'd33);
        check_result("t3b", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        // 4: divide by zero, then a multiply clears the flag
        run_op(OP_DIVU, 32'd5, 32'd0, lat, bcnt);
        check("t4a latency", 64'(lat), 64'd33);
        check_result("t4a", 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_op(OP_MULTU, 32'd3, 32'd4, lat, bcnt);
        check_result("t4b", 32'd0, 32'd12, 1'b0);

        // Signed corner cases: overflow and signed divide by zero keeps raw dividend
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check_result("ovf", 32'h0, 32'h8000_0000, 1'b0);
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, lat, bcnt);
        check_result("sdz", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
        check_result("pos/neg", 32'd1, 32'hFFFF_FFFD, 1'b0);
        tick();

        // 5: operand changes and restart mid-operation are ignored
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        tick();
        bus.start  = 1'b0;
        dones      = 0;
        first_done = 0;
        hi_at_done = '0;
        lo_at_done = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                bus.a = 32'd1000;
                bus.b = 32'd3;
            end
            if (k == 10) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.a     = 32'd2;
                bus.b     = 32'd2;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (bus.done) begin
                dones++;
                if (first_done == 0) begin
                    first_done = k;
                    hi_at_done = bus.hi;
                    lo_at_done = bus.lo;
                end
            end
        end
        check("t5 done count", 64'(dones), 64'd1);
        check("t5 latency", 64'(first_done), 64'd33);
        check("t5 hi", 64'(hi_at_done), 64'd2);
        check("t5 lo", 64'(lo_at_done), 64'd14);

        // 6: asynchronous reset mid-RUN aborts, then a clean rerun
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd6;
        bus.b     = 32'd7;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        check("t6 busy before reset", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t6 busy after reset", 64'(bus.busy), 64'd0);
        check("t6 done after reset", 64'(bus.done), 64'd0);
        check_result("t6 reset", 32'h0, 32'h0, 1'b0);
        #2 reset = 1'b0;
        run_op(OP_MULTU, 32'd6, 32'd7, lat, bcnt);
        check("t6 latency", 64'(lat), 64'd33);
        check_result("t6", 32'd0, 32'd42, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
